// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the decode/execute boundary: control bundle layout,
// register-zero constant and the writeback bypass helper.
package cpu_pkg;

  localparam int CTRL_W         = 8;
  localparam int CTRL_MEMREAD   = 0;
  localparam int CTRL_MEMWRITE  = 1;
  localparam int CTRL_REGWR     = 2;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALUOP_LSB = 5;
  localparam int CTRL_ALUOP_W   = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // What the ID/EX register does on the coming edge.
  typedef enum logic [1:0] {
    SLOT_CAPTURE = 2'd0,
    SLOT_FLUSH   = 2'd1,
    SLOT_BUBBLE  = 2'd2
  } slot_action_e;

  // Register file bypass: a read of the register being written this cycle
  // returns the incoming value. Register zero is hardwired and never bypassed.
  function automatic logic [31:0] bypass(
    input logic [31:0] busVal,
    input logic [4:0]  readAddr,
    input logic        regWr,
    input logic [4:0]  wAddr,
    input logic [31:0] wData
  );
    if (regWr && (wAddr != REG_ZERO) && (wAddr == readAddr)) begin
      return wData;
    end
    return busVal;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/writeback and the ID/EX pipeline register.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = 16
);

  // decode slot
  logic              id_valid;
  logic [31:0]       id_busA;
  logic [31:0]       id_busB;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_dst;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  // writeback port of the register file
  logic              wb_regwr;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_data;

  logic              ex_flush;
  logic              stall;

  // execute slot
  logic              ex_valid;
  logic [31:0]       ex_busA;
  logic [31:0]       ex_busB;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;

  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_busA, id_busB, id_rs, id_rt, id_dst,
           id_uses_rs, id_uses_rt, id_imm, id_ctrl,
           wb_regwr, wb_waddr, wb_data, ex_flush,
    input  stall, ex_valid, ex_busA, ex_busB, ex_rs, ex_rt, ex_dst,
           ex_imm, ex_ctrl, bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_busA, id_busB, id_rs, id_rt, id_dst,
           id_uses_rs, id_uses_rt, id_imm, id_ctrl,
           wb_regwr, wb_waddr, wb_data, ex_flush,
    output stall, ex_valid, ex_busA, ex_busB, ex_rs, ex_rt, ex_dst,
           ex_imm, ex_ctrl, bubble_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// branch flush and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input logic         Clk,
  input logic         Rst,
  id_ex_stage_if.slave bus
);

  import cpu_pkg::*;

  logic [31:0]       opA;
  logic [31:0]       opB;
  logic              hazard;
  slot_action_e      action;
  logic              bubbleInc;
  logic              flushInc;

  logic              exValid;
  logic [31:0]       exBusA;
  logic [31:0]       exBusB;
  logic [4:0]        exRs;
  logic [4:0]        exRt;
  logic [4:0]        exDst;
  logic [31:0]       exImm;
  logic [CTRL_W-1:0] exCtrl;
  logic [CNT_W-1:0]  bubbleCount;
  logic [CNT_W-1:0]  flushCount;

  assign opA = bypass(bus.id_busA, bus.id_rs, bus.wb_regwr, bus.wb_waddr, bus.wb_data);
  assign opB = bypass(bus.id_busB, bus.id_rt, bus.wb_regwr, bus.wb_waddr, bus.wb_data);

  // A load in EX cannot forward in time to a dependent instruction in ID.
  // The bubble clears MEMREAD in EX, so the hazard drops after one cycle.
  always_comb begin
    hazard = exValid && exCtrl[CTRL_MEMREAD] && (exDst != REG_ZERO) && bus.id_valid &&
             ((bus.id_uses_rs && (bus.id_rs == exDst)) ||
              (bus.id_uses_rt && (bus.id_rt == exDst)));
  end

  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    action = SLOT_CAPTURE;
    if (bus.ex_flush) begin
      action = SLOT_FLUSH;
    end else if (hazard) begin
      action = SLOT_BUBBLE;
    end
  end

  assign bus.stall = (action == SLOT_BUBBLE) && !Rst;
  assign bubbleInc = (action == SLOT_BUBBLE);
  assign flushInc  = (action == SLOT_FLUSH) && bus.id_valid;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      exValid <= 1'b0;
      exBusA  <= '0;
      exBusB  <= '0;
      exRs    <= '0;
      exRt    <= '0;
      exDst   <= '0;
      exImm   <= '0;
      exCtrl  <= '0;
    end else begin
      unique case (action)
        SLOT_FLUSH, SLOT_BUBBLE: begin
          // Data fields of a bubble are don't-care; leave them untouched.
          exValid <= 1'b0;
          exCtrl  <= '0;
        end
        default: begin
          exValid <= bus.id_valid;
          exBusA  <= opA;
          exBusB  <= opB;
          exRs    <= bus.id_rs;
          exRt    <= bus.id_rt;
          exDst   <= bus.id_dst;
          exImm   <= bus.id_imm;
          exCtrl  <= bus.id_valid ? bus.id_ctrl : '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (bubbleInc),
    .count (bubbleCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (flushInc),
    .count (flushCount)
  );

  assign bus.ex_valid   = exValid;
  assign bus.ex_busA    = exBusA;
  assign bus.ex_busB    = exBusB;
  assign bus.ex_rs      = exRs;
  assign bus.ex_rt      = exRt;
  assign bus.ex_dst     = exDst;
  assign bus.ex_imm     = exImm;
  assign bus.ex_ctrl    = exCtrl;
  assign bus.bubble_cnt = bubbleCount;
  assign bus.flush_cnt  = flushCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed bypass/hazard/flush/reset cases,
// a random phase, and counter saturation on a narrow-counter instance.
module tb_id_ex_stage;

  import cpu_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  always #5 Clk = ~Clk;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(16)) bus  ();
  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(8))  bus8 ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Narrow counters so saturation is reachable in a short run.
  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(8)) dut8 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus8)
  );

  localparam logic [7:0] C_ADD = 8'h24;  // REGWR + ALUOP=1
  localparam logic [7:0] C_LW  = 8'h0D;  // MEMREAD + REGWR + ALUSRC

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic        dataCare;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [15:0] bubbles;
    logic [15:0] flushes;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // reference model of the EX slot and counters
  logic        mValid   = 1'b0;
  logic [7:0]  mCtrl    = '0;
  logic [4:0]  mDst     = '0;
  logic [15:0] mBubbles = '0;
  logic [15:0] mFlushes = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setSlot(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic urs, input logic urt,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [7:0] ctrl);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_dst     = dst;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_busA    = a;
    bus.id_busB    = b;
    bus.id_imm     = imm;
    bus.id_ctrl    = ctrl;
  endtask

  task automatic setWb(input logic wr, input logic [4:0] wa, input logic [31:0] wd);
    bus.wb_regwr = wr;
    bus.wb_waddr = wa;
    bus.wb_data  = wd;
  endtask

  // Predict the edge from the current inputs, push it, clock, pop and compare.
  task automatic step(output logic stalled);
    exp_t e;
    logic hz;
    #1;
    hz = mValid && mCtrl[CTRL_MEMREAD] && (mDst != 5'd0) && bus.id_valid &&
         ((bus.id_uses_rs && (bus.id_rs == mDst)) || (bus.id_uses_rt && (bus.id_rt == mDst)));
    stalled = hz && !bus.ex_flush;
    check("stall", bus.stall, stalled);
    e = '{default: '0};
    if (bus.ex_flush) begin
      if (bus.id_valid && (mFlushes != 16'hFFFF)) mFlushes++;
    end else if (hz) begin
      if (mBubbles != 16'hFFFF) mBubbles++;
    end else begin
      e.valid    = bus.id_valid;
      e.ctrl     = bus.id_valid ? bus.id_ctrl : 8'h00;
      e.dataCare = 1'b1;
      e.busA     = (bus.wb_regwr && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == bus.id_rs)) ?
                   bus.wb_data : bus.id_busA;
      e.busB     = (bus.wb_regwr && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == bus.id_rt)) ?
                   bus.wb_data : bus.id_busB;
      e.rs       = bus.id_rs;
      e.rt       = bus.id_rt;
      e.dst      = bus.id_dst;
      e.imm      = bus.id_imm;
      mDst       = bus.id_dst;
    end
    e.bubbles = mBubbles;
    e.flushes = mFlushes;
    mValid    = e.valid;
    mCtrl     = e.ctrl;
    sbq.push_back(e);
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    check("ex_valid", bus.ex_valid, e.valid);
    check("ex_ctrl", bus.ex_ctrl, e.ctrl);
    if (e.dataCare) begin
      check("ex_busA", bus.ex_busA, e.busA);
      check("ex_busB", bus.ex_busB, e.busB);
      check("ex_rs", bus.ex_rs, e.rs);
      check("ex_rt", bus.ex_rt, e.rt);
      check("ex_dst", bus.ex_dst, e.dst);
      check("ex_imm", bus.ex_imm, e.imm);
    end
    check("bubble_cnt", bus.bubble_cnt, e.bubbles);
    check("flush_cnt", bus.flush_cnt, e.flushes);
  endtask

  initial begin
    logic st;
    logic [4:0] rs, rt, dst;
    logic urs, urt, v;
    logic [31:0] a, b, imm;
    logic [7:0] ctrl;

    setSlot(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    setWb(1'b0, 5'd0, '0);
    bus.ex_flush = 1'b0;
    bus8.id_valid = 1'b0;  bus8.id_rs = '0;      bus8.id_rt = '0;
    bus8.id_dst = '0;      bus8.id_uses_rs = 1'b0; bus8.id_uses_rt = 1'b0;
    bus8.id_busA = '0;     bus8.id_busB = '0;    bus8.id_imm = '0;
    bus8.id_ctrl = '0;     bus8.wb_regwr = 1'b0; bus8.wb_waddr = '0;
    bus8.wb_data = '0;     bus8.ex_flush = 1'b0;

    #12;
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_ctrl", bus.ex_ctrl, 8'h00);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_bubble", bus.bubble_cnt, 16'h0);
    check("rst_flush", bus.flush_cnt, 16'h0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // writeback bypass on A, on B, never for r0, not when RegWr is low
    setSlot(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'h10, C_ADD);
    setWb(1'b1, 5'd5, 32'hDEADBEEF);
    step(st);
    check("byp_a", bus.ex_busA, 32'hDEADBEEF);
    check("byp_a_other", bus.ex_busB, 32'h22222222);
    setSlot(1'b1, 5'd5, 5'd7, 5'd9, 1'b1, 1'b1, 32'h33333333, 32'h44444444, 32'h20, C_ADD);
    setWb(1'b1, 5'd7, 32'hCAFEF00D);
    step(st);
    check("byp_b", bus.ex_busB, 32'hCAFEF00D);
    check("byp_b_other", bus.ex_busA, 32'h33333333);
    setSlot(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h55555555, 32'h66666666, 32'h30, C_ADD);
    setWb(1'b1, 5'd0, 32'hBAD0BAD0);
    step(st);
    check("byp_r0", bus.ex_busA, 32'h55555555);
    setSlot(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h40, C_ADD);
    setWb(1'b0, 5'd5, 32'hBAD0BAD0);
    step(st);
    check("byp_nowr", bus.ex_busA, 32'h12345678);
    setWb(1'b0, 5'd0, '0);

    // non-load producer: no stall, EX sees the registered BusA
    setSlot(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
    step(st);
    setSlot(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 32'h77777777, 32'h2, 32'h0, C_ADD);
    step(st);
    check("nonload_valid", bus.ex_valid, 1'b1);
    check("nonload_busA", bus.ex_busA, 32'h77777777);

    // load-use on rs: one bubble, then the re-presented consumer is captured
    setSlot(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd8, 5'd3, 5'd11, 1'b1, 1'b1, 32'h88888888, 32'h3, 32'h0, C_ADD);
    #1;
    check("lu_stall", bus.stall, 1'b1);
    step(st);
    check("lu_bubble_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_cnt", bus.bubble_cnt, 16'd1);
    step(st);
    check("lu_replay_stall", st, 1'b0);
    check("lu_replay_valid", bus.ex_valid, 1'b1);
    check("lu_replay_busA", bus.ex_busA, 32'h88888888);

    // load-use on rt; same register but uses_rt=0 must not stall
    setSlot(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd3, 5'd12, 5'd13, 1'b1, 1'b1, 32'h3, 32'hAAAA0000, 32'h0, C_ADD);
    step(st);
    step(st);
    setSlot(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd3, 5'd12, 5'd13, 1'b1, 1'b0, 32'h3, 32'hBBBB0000, 32'h8, C_LW);
    step(st);
    check("rt_unused_valid", bus.ex_valid, 1'b1);

    // back-to-back loads with a dependent third instruction
    setSlot(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 32'h1, 32'h2, 32'h8, C_LW);
    step(st);
    step(st);
    setSlot(1'b1, 5'd9, 5'd2, 5'd14, 1'b1, 1'b1, 32'hC0DE0000, 32'h2, 32'h0, C_ADD);
    step(st);
    step(st);
    check("b2b_bubbles", bus.bubble_cnt, 16'd4);

    // flush wins over a simultaneous hazard
    setSlot(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd10, 5'd2, 5'd15, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
    bus.ex_flush = 1'b1;
    #1;
    check("fl_stall", bus.stall, 1'b0);
    step(st);
    check("fl_valid", bus.ex_valid, 1'b0);
    check("fl_flush_cnt", bus.flush_cnt, 16'd1);
    check("fl_bubble_cnt", bus.bubble_cnt, 16'd4);
    bus.id_valid = 1'b0;
    step(st);
    check("fl_idle_cnt", bus.flush_cnt, 16'd1);
    bus.ex_flush = 1'b0;

    // random traffic on a small register range so hazards and bypasses collide
    st = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!st) begin
        v    = ($urandom_range(0, 3) != 0);
        rs   = 5'($urandom_range(0, 3));
        rt   = 5'($urandom_range(0, 3));
        dst  = 5'($urandom_range(0, 3));
        urs  = 1'($urandom_range(0, 1));
        urt  = 1'($urandom_range(0, 1));
        a    = $urandom;
        b    = $urandom;
        imm  = $urandom;
        ctrl = 8'($urandom_range(0, 255));
        setSlot(v, rs, rt, dst, urs, urt, a, b, imm, ctrl);
      end
      setWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.ex_flush = ($urandom_range(0, 9) == 0);
      step(st);
    end
    bus.ex_flush = 1'b0;
    setWb(1'b0, 5'd0, '0);

    // asynchronous reset in the middle of a stall cycle
    setSlot(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4, C_LW);
    step(st);
    setSlot(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, C_ADD);
    #1;
    check("mid_pre_valid", bus.ex_valid, 1'b1);
    check("mid_pre_stall", bus.stall, 1'b1);
    #2;
    Rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.ex_valid, 1'b0);
    check("mid_rst_ctrl", bus.ex_ctrl, 8'h00);
    check("mid_rst_stall", bus.stall, 1'b0);
    check("mid_rst_bubble", bus.bubble_cnt, 16'h0);
    check("mid_rst_flush", bus.flush_cnt, 16'h0);
    Rst = 1'b0;
    mValid = 1'b0; mCtrl = '0; mBubbles = '0; mFlushes = '0;
    step(st);
    check("mid_after_valid", bus.ex_valid, 1'b1);

    // saturation on the 8-bit instance: 260 load-use bubbles, then 260 flushes
    bus8.id_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus8.id_rs = 5'd1; bus8.id_uses_rs = 1'b0; bus8.id_dst = 5'd3; bus8.id_ctrl = C_LW;
      @(posedge Clk); #1;
      bus8.id_rs = 5'd3; bus8.id_uses_rs = 1'b1; bus8.id_dst = 5'd4; bus8.id_ctrl = C_ADD;
      @(posedge Clk); #1;
      if (i == 0)   check("sat_bub_first", bus8.bubble_cnt, 8'd1);
      if (i == 254) check("sat_bub_255", bus8.bubble_cnt, 8'hFF);
    end
    check("sat_bub_hold", bus8.bubble_cnt, 8'hFF);
    bus8.ex_flush = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(posedge Clk); #1;
      if (i == 254) check("sat_fl_255", bus8.flush_cnt, 8'hFF);
    end
    check("sat_fl_hold", bus8.flush_cnt, 8'hFF);
    check("sat_bub_still", bus8.bubble_cnt, 8'hFF);
    bus8.ex_flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage fed directly by the RegisterFile read ports (BusA/BusB) and decode control.
- Applies a writeback bypass, so an operand read in the same cycle that the register file is written returns the new value.
- Detects load-use hazards, inserts one bubble, and stalls IF/ID for that cycle.
- Handles branch flush and keeps saturating bubble/flush event counters for the cosim bench.

Parameters:
CTRL_W, 8, width of decoded control bundle; bit indices are defined in cpu_pkg
CNT_W, 16, width of the bubble and flush counters

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
id_valid  input  1  decode slot holds a real instruction
id_busA  input  32  RegisterFile BusA (value of id_rs)
id_busB  input  32  RegisterFile BusB (value of id_rt)
id_rs  input  5  source register A number
id_rt  input  5  source register B number
id_dst  input  5  destination register (rt/rd mux already resolved by decode)
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_imm  input  32  sign/zero-extended immediate
id_ctrl  input  CTRL_W  decoded control bundle
wb_regwr  input  1  writeback stage writes RegisterFile this cycle (RegWr)
wb_waddr  input  5  writeback destination (RW)
wb_data  input  32  writeback data (BusW)
ex_flush  input  1  branch/jump resolved taken in EX; kill the decode slot
stall  output  1  combinational; hold PC and IF/ID this cycle
ex_valid  output  1  EX slot holds a real instruction
ex_busA  output  32  registered operand A
ex_busB  output  32  registered operand B
ex_rs  output  5  registered rs (for EX forwarding)
ex_rt  output  5  registered rt
ex_dst  output  5  registered destination
ex_imm  output  32  registered immediate
ex_ctrl  output  CTRL_W  registered control; all-zero when not valid
bubble_cnt  output  CNT_W  load-use bubbles inserted, saturating
flush_cnt  output  CNT_W  flushes applied to a valid decode slot, saturating

Behaviour:
- Reset (async, Rst=1): all registered outputs go to 0 immediately, including both counters. stall reads 0 while Rst=1.
- Bypass (combinational):
  - opA = wb_data if wb_regwr && wb_waddr!=0 && wb_waddr==id_rs; otherwise opA = id_busA.
  - opB is formed the same way using id_rt.
  - Register 0 is never bypassed.
- Hazard (combinational): hz = ex_valid && ex_ctrl[CTRL_MEMREAD] && ex_dst!=0 && id_valid && ((id_uses_rs && id_rs==ex_dst) || (id_uses_rt && id_rt==ex_dst)).
- stall = hz && !ex_flush.
- Register update each edge, in priority order:
  1. ex_flush=1 → bubble: ex_valid<=0, ex_ctrl<=0. Flush wins over hazard. If id_valid=1, flush_cnt increments.
  2. hz=1 → bubble: ex_valid<=0, ex_ctrl<=0; bubble_cnt increments. IF/ID holds via stall, so the same instruction is re-presented next cycle.
  3. Otherwise capture the decode slot: ex_valid<=id_valid; ex_busA<=opA; ex_busB<=opB; ex_rs/ex_rt/ex_dst/ex_imm take the id_ fields; ex_ctrl<=id_valid ? id_ctrl : 0.
- Bubble data fields (busA/B, rs, rt, dst, imm) are don't-care. The bench checks only ex_valid and ex_ctrl during bubbles.
- Latency is 1 cycle from decode to EX. A load-use costs exactly one bubble, because the bubble clears ex_ctrl[CTRL_MEMREAD] and hz drops on the next cycle.
- Back-to-back loads with a dependent third instruction: each load-use pair stalls once, and no double stall occurs.
- Counters saturate at all-ones and never wrap.
- Rst mid-stall: state clears, stall drops, and the EX slot becomes invalid.
- id_valid=0 with ex_flush=1: a bubble is inserted and flush_cnt does not change.

Decomposition:
- cpu_pkg holds:
  - CTRL_W
  - control bit indices CTRL_MEMREAD=0, CTRL_MEMWRITE=1, CTRL_REGWR=2, CTRL_ALUSRC=3, CTRL_BRANCH=4, CTRL_ALUOP_LSB=5 (3 bits)
  - REG_ZERO=5'd0
- Sub-module sat_counter (parameter W; ports Clk, Rst, inc, count), instantiated twice.

Test Plan:
1. Reset: assert Rst asynchronously mid-cycle with ex_valid=1 → ex_valid=0, ex_ctrl=0, bubble_cnt=0, flush_cnt=0 immediately, before the next edge.
2. Bypass: id_rs=5, id_busA=32'h11111111, wb_regwr=1, wb_waddr=5, wb_data=32'hDEADBEEF → ex_busA=32'hDEADBEEF after the edge. Repeat with id_rs=0, wb_waddr=0 → ex_busA=id_busA.
3. Load-use: lw to dst=8 captured, then the next instruction has id_rs=8, uses_rs=1 → stall=1 for one cycle and ex_valid=0 on the next edge. bubble_cnt=1. The re-presented instruction is captured on the following edge with stall=0.
4. Flush vs hazard: hz condition true and ex_flush=1 together → stall=0, ex_valid=0, flush_cnt +1, bubble_cnt unchanged.
5. Saturation: force 65540 load-use bubbles → bubble_cnt holds at 16'hFFFF.
6. Non-load dependency: add with dst=8, then a consumer with rs=8 → stall=0 and no bubble; ex_busA = registered BusA, since forwarding is EX's responsibility.
